// File: rtl/bus_slave_sel.sv
// rtl/bus_slave_sel.sv - registered slave decoder with chip selects, ready merge and error completion (optional watchdog: BUS_TIMEOUT_EN)
module bus_slave_sel #(
   parameter int SLAVE_NUM = 8,
   parameter int INDEX_W   = 3,
   parameter int ADDR_W    = 30,
   parameter int TIMEOUT   = 255
) (
   input  logic                 clk,
   input  logic                 reset_,
   input  logic [ADDR_W-1:0]    s_addr,
   input  logic                 s_as_,
   input  logic [SLAVE_NUM-1:0] s_rdy_,
   output logic [SLAVE_NUM-1:0] cs_,
   output logic                 rdy_,
   output logic                 bus_err,
   output logic [ADDR_W-1:0]    err_addr
);

   typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

   state_t                 state, state_nx;
   logic [INDEX_W-1:0]     idx;
   logic [INDEX_W-1:0]     idx_in;
   logic                   mapped;
   logic [SLAVE_NUM-1:0]   cs_sel;
   logic [SLAVE_NUM-1:0]   cs_nx;
   logic                   sel_rdy;
   logic [ADDR_W-1:0]      err_addr_nx;

`ifdef BUS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]       cnt;
   logic [ADDR_W-1:0]      addr;
   logic                   expired;

   // Last allowed BUSY cycle: counter has reached TIMEOUT-1 without a ready
   assign expired = (cnt == CNT_W'(TIMEOUT - 1));
`endif

   assign idx_in = s_addr[ADDR_W-1 -: INDEX_W];
   assign mapped = (32'(idx_in) < 32'(SLAVE_NUM));

   // Decode the incoming index to a chip-select pattern and pick the ready of the latched slave
   always_comb begin
      cs_sel  = '1;
      sel_rdy = 1'b1;
      for (int i = 0; i < SLAVE_NUM; i++) begin
         if (idx_in == INDEX_W'(i)) cs_sel[i] = 1'b0;
         if (idx == INDEX_W'(i))    sel_rdy   = s_rdy_[i];
      end
   end

   // Next-state, next chip selects and the merged ready to the master
   always_comb begin
      state_nx    = state;
      cs_nx       = cs_;
      rdy_        = 1'b1;
      err_addr_nx = s_addr;
`ifdef BUS_TIMEOUT_EN
      if (state == BUSY) err_addr_nx = addr;
`endif
      case (state)
         IDLE: begin
            if (!s_as_) begin
               if (mapped) begin
                  state_nx = BUSY;
                  cs_nx    = cs_sel;
               end else begin
                  state_nx = ERR;
               end
            end
         end
         BUSY: begin
            rdy_ = sel_rdy;
            // Ready wins over an expiring watchdog on the same cycle
            if (!sel_rdy) begin
               state_nx = IDLE;
               cs_nx    = '1;
            end
`ifdef BUS_TIMEOUT_EN
            else if (expired) begin
               state_nx = ERR;
               cs_nx    = '1;
            end
`endif
         end
         ERR: begin
            rdy_     = 1'b0;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
            cs_nx    = '1;
         end
      endcase
   end

   // State, registered chip selects and the error report, loaded as ERR is entered
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state    <= IDLE;
         cs_      <= '1;
         bus_err  <= 1'b0;
         err_addr <= '0;
         idx      <= '0;
      end else begin
         state   <= state_nx;
         cs_     <= cs_nx;
         bus_err <= (state_nx == ERR);
         if (state_nx == ERR) err_addr <= err_addr_nx;
         if (state == IDLE && !s_as_) idx <= idx_in;
      end
   end

`ifdef BUS_TIMEOUT_EN
   // Watchdog: cleared when an access starts, counts BUSY cycles without ready
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         cnt  <= '0;
         addr <= '0;
      end else if (state == IDLE && !s_as_) begin
         cnt  <= '0;
         addr <= s_addr;
      end else if (state == BUSY && !expired) begin
         cnt  <= cnt + CNT_W'(1);
      end
   end
`endif

endmodule
